apb_wait_slave: RTL
===================

Name: apb_wait_slave

Overview:
APB completer that sits directly downstream of the APB master (m1) inside top and consumes its psel/penable/pwrite/paddr/pwdata bus. It holds a small 8-bit register file, inserts wait states from a fixed minimum plus the external s_wait stall input, and returns pready/prdata/pslverr. It is the stage the wait-state bench exercises through dut.m1.pready.

Parameters:
MEM_DEPTH, 12, number of implemented 8-bit registers; legal addresses are 0..MEM_DEPTH-1, max 16.
MIN_WAIT, 0, fixed extra access-phase cycles before pready may assert, range 0..15.

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  synchronous active-low reset
psel  input  1  APB select from master
penable  input  1  APB enable (access phase)
pwrite  input  1  1 = write, 0 = read
paddr  input  4  register address
pwdata  input  8  write data
s_wait  input  1  external stall; while 1, pready is held low
prdata  output  8  read data, registered
pready  output  1  transfer-complete strobe, registered
pslverr  output  1  error response, valid only while pready = 1

Behaviour:
- Reset (rstn = 0 at a rising edge): state IDLE, pready = 0, pslverr = 0, prdata = 8'h00, all MEM_DEPTH registers = 8'h00, wait counter = 0. Reset mid-transfer aborts the transfer with no write.
- FSM states: IDLE, WAIT, DONE.
- IDLE: on psel = 1 and penable = 0 (setup phase), latch paddr, pwrite, pwdata; load counter = MIN_WAIT; go to WAIT. penable = 1 seen in IDLE without a prior setup is ignored.
- WAIT: if psel = 0, abort to IDLE with no write and pready = 0. Otherwise, with penable = 1: if counter > 0, decrement. If counter = 0 and s_wait = 0, complete the transfer on this edge:
  - pready <= 1.
  - err = latched address >= MEM_DEPTH.
  - Write: mem[addr] <= latched wdata if !err.
  - Read: prdata <= err ? 8'h00 : mem[addr].
  - pslverr <= err.
  - Go to DONE.
  If s_wait = 1, hold: counter stays 0 and pready stays 0.
- DONE: pready and pslverr are high for exactly this one cycle. At the next edge pready <= 0, pslverr <= 0, go to IDLE. A new setup phase arriving in that same cycle is not accepted; the master must return to IDLE first, per APB.
- Latency: the access phase lasts 2 + MIN_WAIT + N cycles (N = access-phase cycles with s_wait = 1, counted after the counter reaches 0). pready therefore asserts no earlier than the second access cycle; there is no zero-wait completion.
- Latched address and data are used for the whole transfer. Changes on paddr or pwdata during the access phase are ignored.
- prdata holds its last value between reads and is not changed by writes.
- Stall overlap: s_wait asserted while the counter is still nonzero does not pause the counter. The stall adds only the cycles during which s_wait is still 1 once the counter reaches 0.
- pslverr is never 1 while pready = 0.

Test Plan:
- Write 8'hA5 to addr 3 (MIN_WAIT = 0, s_wait = 0) -> pready high for 1 cycle, 2 access cycles total, pslverr = 0, mem[3] = 8'hA5.
- Read addr 3 after the write above -> prdata = 8'hA5 in the pready cycle and held afterwards, pslverr = 0.
- Write addr 1 with s_wait = 1 for the first 3 access cycles -> pready first high in access cycle 5, exactly 1 cycle wide, write occurs once.
- Write 8'h77 to addr 13, then read addr 13 (MEM_DEPTH = 12) -> pslverr = 1 with pready on both; no register changes; read returns prdata = 8'h00.
- Drop psel during WAIT with s_wait = 1 on a write to addr 2 -> FSM back to IDLE, pready never asserts, mem[2] unchanged.
- Assert rstn = 0 during WAIT after prior writes -> next cycle pready = 0, pslverr = 0, prdata = 8'h00, all registers read back 8'h00.

Source files
------------

// File: rtl/apb_wait_slave.sv
// APB completer with a small 8-bit register file and wait-state insertion:
// a fixed MIN_WAIT count followed by the external s_wait stall.
module apb_wait_slave #(
    parameter int MEM_DEPTH = 12,
    parameter int MIN_WAIT  = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [3:0] paddr,
    input  logic [7:0] pwdata,
    input  logic       s_wait,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] MIN_WAIT_C  = 4'(MIN_WAIT);
    localparam logic [4:0] MEM_DEPTH_C = 5'(MEM_DEPTH);

    logic [1:0] state_q,   state_d;
    logic [3:0] cnt_q,     cnt_d;
    logic [3:0] addr_q,    addr_d;
    logic       write_q,   write_d;
    logic [7:0] wdata_q,   wdata_d;
    logic [7:0] prdata_q,  prdata_d;
    logic       pready_q,  pready_d;
    logic       pslverr_q, pslverr_d;
    logic [7:0] mem_q [MEM_DEPTH];
    logic [7:0] mem_d [MEM_DEPTH];

    logic       err_s;
    logic [7:0] rd_data_s;

    // Address decode and read mux over the implemented registers
    always_comb begin
        err_s     = ({1'b0, addr_q} >= MEM_DEPTH_C);
        rd_data_s = 8'h00;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            if (addr_q == i[3:0]) begin
                rd_data_s = mem_q[i];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
    end

    // Transfer FSM: setup latch, wait countdown/stall, single-cycle completion
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        mem_d     = mem_q;
        case (state_q)
            ST_IDLE: begin
                if (psel && !penable) begin
                    addr_d  = paddr;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    cnt_d   = MIN_WAIT_C;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    state_d = ST_IDLE;
                end else if (penable) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else if (!s_wait) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_s;
                        state_d   = ST_DONE;
                        if (write_q) begin
                            for (int i = 0; i < MEM_DEPTH; i++) begin
                                if (!err_s && addr_q == i[3:0]) begin
                                    mem_d[i] = wdata_q;
                                end else begin
                                    mem_d[i] = mem_q[i];
                                end
                            end
                        end else begin
                            prdata_d = err_s ? 8'h00 : rd_data_s;
                        end
                    end else begin
                        cnt_d = 4'd0;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                // Any setup seen here is dropped; the master idles first.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and register file flops with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 4'd0;
            write_q   <= 1'b0;
            wdata_q   <= 8'h00;
            prdata_q  <= 8'h00;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule
